reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- 32-entry MIPS general-purpose register file: two combinational read ports (rs, rt) and one write-back port, with write-first bypass.
- Adds a per-register pending-write scoreboard (2-bit counters) that generates the decode-stage stall for RAW hazards.
- Sits between ID (read/issue side) and WB (write side).
- It is the read-side counterpart of the pipeline's single write-enabled registers: the producer writes through the WB port, and consumers read through the rs/rt ports.

Parameters:
- bREG, 32, data width of each register
- bADDR, 5, register address width (2**bADDR entries)
- bCNT, 2, pending-write counter width per register (max 2**bCNT-1 outstanding writers)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- rs_addr  input  bADDR  read port A address
- rt_addr  input  bADDR  read port B address
- rs_used  input  1  instruction in ID consumes rs
- rt_used  input  1  instruction in ID consumes rt
- rs_data  output  bREG  read port A data
- rt_data  output  bREG  read port B data
- issue_en  input  1  instruction leaving ID will write issue_addr
- issue_addr  input  bADDR  destination of issuing instruction
- wb_en  input  1  write-back valid
- wb_addr  input  bADDR  write-back destination
- wb_data  input  bREG  write-back data
- sq_en  input  1  squash of one in-flight writer (flush)
- sq_addr  input  bADDR  destination of squashed writer
- stall  output  1  RAW or counter-full hazard; ID must hold
- ovf_err  output  1  sticky: issue attempted with counter saturated
- unf_err  output  1  sticky: wb/squash to register with counter 0

Behaviour:
- Reset (reset=0, async): all registers=0, all counters=0, ovf_err=unf_err=0. rs_data/rt_data therefore read 0. stall=0.
- Register 0: reads always 0; writes, issues and squashes targeting 0 are ignored (no counter change, no error).
- Write: on rising clock with wb_en and wb_addr!=0, mem[wb_addr]<=wb_data.
- Read (combinational): rs_data = 0 if rs_addr==0; else wb_data if wb_en && wb_addr==rs_addr (bypass); else mem[rs_addr]. rt is identical.
- Counter update per register r each clock, with inc = issue_en && issue_addr==r and dec = (wb_en && wb_addr==r) + (sq_en && sq_addr==r), range 0..2:
  - next = cnt + inc - dec, evaluated as a signed intermediate.
  - If next<0: counter set to 0, unf_err<=1.
  - If next > max (2**bCNT-1): counter held at max, ovf_err<=1.
  - Simultaneous issue and wb to the same r: net zero, no change.
- stall (combinational) = hz_rs | hz_rt | hz_full:
  - hz_rs = rs_used && rs_addr!=0 && eff_cnt(rs_addr)!=0
  - hz_rt = rt_used && rt_addr!=0 && eff_cnt(rt_addr)!=0
  - hz_full = issue_en && issue_addr!=0 && cnt[issue_addr]==max
  - eff_cnt(r) = cnt[r] - (wb_en && wb_addr==r ? 1 : 0). A value arriving this cycle is bypassed, so a last-outstanding writer completing does not stall.
- Issue while stall=1 is a protocol error by the driver. The block still applies the counter rules above.
- Errors clear only on reset.
- No pipeline latency through the block: read data and stall are valid in the same cycle; state updates take effect on the next edge.

Decomposition:
- Shared package mips_pkg: register-count constant (32), address width (5), data width (32), and ZERO_REG=0.
- Optional single sub-module pend_counter, instantiated once per register. It implements the inc/dec/saturate logic and produces per-register ovf/unf pulses, which the top ORs into the sticky flags.
- Storage array, bypass muxes and hazard logic stay in the top module.

Test Plan:
- Reset then read: assert reset=0 mid-run after writes → rs_data=rt_data=0 for all addresses, stall=0, errors=0, immediately (async).
- Write/read with bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, rs_addr=5 → rs_data=0xDEADBEEF in the same cycle; the next cycle with wb_en=0 still reads 0xDEADBEEF. A write to r0 with 0x1234 → r0 reads 0.
- RAW stall:
  - issue_en to r8, next cycle rs_addr=8, rs_used=1 → stall=1.
  - With rs_used=0 → stall=0.
  - Cycle with wb_en to r8 (value 0x55) → stall=0 and rs_data=0x55.
- Counter saturation: three issues to r3 (cnt=3), then issue_en to r3 → stall=1.
  - Forcing the issue → cnt stays 3, ovf_err=1.
  - Three wbs → cnt 0.
  - A fourth wb → unf_err=1, data still written.
- Simultaneous events:
  - With cnt[r9]=1, issue r9 and wb r9 in the same cycle → cnt[r9] stays 1 and mem[r9] is updated.
  - With cnt[r4]=2, wb r4 plus sq r4 → cnt 0, no error.
- Squash flush: issue r10, sq_en r10 next cycle → cnt 0, stall for rs=10 drops, mem[r10] unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants: register count, address/data widths
// and the hard-wired zero register index.
package mips_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/pend_counter.sv
// Pending-write counter for one architectural register: +1 per issue, -1 per
// write-back or squash, saturating at 0 and max with one-cycle error pulses.
module pend_counter #(
  parameter int bCNT = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic [1:0]      dec,
  output logic [bCNT-1:0] cnt,
  output logic            ovf,
  output logic            unf
);
  localparam logic [bCNT-1:0]          CNT_MAX   = '1;
  localparam logic signed [bCNT+2:0]   CNT_MAX_S = signed'({3'b000, CNT_MAX});

  logic [bCNT-1:0]        cnt_reg, cnt_next;
  logic signed [bCNT+2:0] sum;

  // Three extra bits keep cnt+1 and cnt-2 both representable as signed.
  always_comb begin
    sum = signed'({3'b000, cnt_reg})
        + signed'({{(bCNT+2){1'b0}}, inc})
        - signed'({{(bCNT+1){1'b0}}, dec});
    cnt_next = cnt_reg;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (sum[bCNT+2]) begin
      cnt_next = '0;
      unf      = 1'b1;
    end else if (sum > CNT_MAX_S) begin
      cnt_next = CNT_MAX;
      ovf      = 1'b1;
    end else begin
      cnt_next = sum[bCNT-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;
endmodule

// File: rtl/reg_file_scoreboard.sv
// 32-entry MIPS register file with write-first bypass and a per-register
// pending-write scoreboard that raises the decode-stage RAW stall.
module reg_file_scoreboard
  import mips_pkg::*;
#(
  parameter int bREG  = DATA_W,
  parameter int bADDR = ADDR_W,
  parameter int bCNT  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [bADDR-1:0] rs_addr,
  input  logic [bADDR-1:0] rt_addr,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic [bREG-1:0]  rs_data,
  output logic [bREG-1:0]  rt_data,
  input  logic             issue_en,
  input  logic [bADDR-1:0] issue_addr,
  input  logic             wb_en,
  input  logic [bADDR-1:0] wb_addr,
  input  logic [bREG-1:0]  wb_data,
  input  logic             sq_en,
  input  logic [bADDR-1:0] sq_addr,
  output logic             stall,
  output logic             ovf_err,
  output logic             unf_err
);
  localparam int N = (bADDR == ADDR_W) ? NUM_REGS : (1 << bADDR);
  localparam logic [bADDR-1:0] ZERO_A  = bADDR'(ZERO_REG);
  localparam logic [bCNT-1:0]  CNT_MAX = '1;

  // Register 0 has no storage and no counter at all.
  logic [bREG-1:0] mem_reg [1:N-1];
  logic [bCNT-1:0] cnt     [1:N-1];
  logic [N-1:1]    ovf_pulse, unf_pulse;
  logic            ovf_err_reg, unf_err_reg;

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_reg
      logic wb_hit, sq_hit, iss_hit;
      assign wb_hit  = wb_en    && (wb_addr    == bADDR'(gi));
      assign sq_hit  = sq_en    && (sq_addr    == bADDR'(gi));
      assign iss_hit = issue_en && (issue_addr == bADDR'(gi));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset)      mem_reg[gi] <= '0;
        else if (wb_hit) mem_reg[gi] <= wb_data;
      end

      pend_counter #(.bCNT(bCNT)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (iss_hit),
        .dec   ({1'b0, wb_hit} + {1'b0, sq_hit}),
        .cnt   (cnt[gi]),
        .ovf   (ovf_pulse[gi]),
        .unf   (unf_pulse[gi])
      );
    end
  endgenerate

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != ZERO_A)
      rs_data = (wb_en && wb_addr == rs_addr) ? wb_data : mem_reg[rs_addr];
    if (rt_addr != ZERO_A)
      rt_data = (wb_en && wb_addr == rt_addr) ? wb_data : mem_reg[rt_addr];
  end

  // A write-back landing this cycle is bypassed, so it retires one pending count.
  logic [bCNT:0] eff_rs, eff_rt;
  logic          hz_rs, hz_rt, hz_full;

  always_comb begin
    eff_rs  = '0;
    eff_rt  = '0;
    hz_full = 1'b0;
    if (rs_addr != ZERO_A)
      eff_rs = {1'b0, cnt[rs_addr]} - {{bCNT{1'b0}}, (wb_en && wb_addr == rs_addr)};
    if (rt_addr != ZERO_A)
      eff_rt = {1'b0, cnt[rt_addr]} - {{bCNT{1'b0}}, (wb_en && wb_addr == rt_addr)};
    if (issue_en && issue_addr != ZERO_A)
      hz_full = (cnt[issue_addr] == CNT_MAX);
    hz_rs = rs_used && (rs_addr != ZERO_A) && (eff_rs != '0);
    hz_rt = rt_used && (rt_addr != ZERO_A) && (eff_rt != '0);
  end

  assign stall = hz_rs | hz_rt | hz_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_err_reg <= 1'b0;
      unf_err_reg <= 1'b0;
    end else begin
      ovf_err_reg <= ovf_err_reg | (|ovf_pulse);
      unf_err_reg <= unf_err_reg | (|unf_pulse);
    end
  end

  assign ovf_err = ovf_err_reg;
  assign unf_err = unf_err_reg;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: bypass, RAW stall, saturation,
// simultaneous events, squash and asynchronous mid-run reset.
module tb_reg_file_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, issue_addr, wb_addr, sq_addr;
  logic        rs_used, rt_used, issue_en, wb_en, sq_en;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        stall, ovf_err, unf_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_scoreboard dut (
    .clock(clock), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sq_en(sq_en), .sq_addr(sq_addr),
    .stall(stall), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_en = 0; wb_en = 0; sq_en = 0; rs_used = 0; rt_used = 0;
  endtask

  initial begin
    reset = 0; idle();
    rs_addr = 0; rt_addr = 0; issue_addr = 0; wb_addr = 0; sq_addr = 0; wb_data = 0;
    #2;
    rs_addr = 5; rt_addr = 9; rs_used = 1; rt_used = 1;
    #1;
    chk("rst_rs", rs_data, 0);
    chk("rst_rt", rt_data, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_err", {30'd0, ovf_err, unf_err}, 0);
    #4 reset = 1; idle();
    tick();

    // bypass write to r5 after issuing it
    issue_en = 1; issue_addr = 5;
    tick(); idle();
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rs_addr = 5; rt_addr = 5;
    #1;
    chk("byp_rs", rs_data, 32'hDEADBEEF);
    chk("byp_rt", rt_data, 32'hDEADBEEF);
    tick(); idle();
    #1;
    chk("stored_rs", rs_data, 32'hDEADBEEF);
    chk("no_unf_r5", {31'd0, unf_err}, 0);

    // write to r0 is ignored, no error
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234; rs_addr = 0;
    #1;
    chk("r0_byp", rs_data, 0);
    tick(); idle();
    #1;
    chk("r0_read", rs_data, 0);
    chk("r0_no_unf", {31'd0, unf_err}, 0);

    // RAW stall on r8
    issue_en = 1; issue_addr = 8;
    tick(); idle();
    rs_addr = 8; rs_used = 1;
    #1;
    chk("raw_stall", {31'd0, stall}, 1);
    rs_used = 0;
    #1;
    chk("raw_unused", {31'd0, stall}, 0);
    rt_addr = 8; rt_used = 1;
    #1;
    chk("raw_rt_stall", {31'd0, stall}, 1);
    rt_used = 0; rs_used = 1; wb_en = 1; wb_addr = 8; wb_data = 32'h55;
    #1;
    chk("raw_wb_stall", {31'd0, stall}, 0);
    chk("raw_wb_data", rs_data, 32'h55);
    tick(); idle(); rs_used = 1;
    #1;
    chk("raw_after", {31'd0, stall}, 0);
    chk("raw_after_d", rs_data, 32'h55);
    idle();

    // issue+wb to r9 same cycle keeps cnt=1
    issue_en = 1; issue_addr = 9;
    tick(); idle();
    issue_en = 1; issue_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    tick(); idle();
    rs_addr = 9; rs_used = 1;
    #1;
    chk("sim_cnt1", {31'd0, stall}, 1);
    chk("sim_data", rs_data, 32'h99);
    wb_en = 1; wb_addr = 9; wb_data = 32'h9A;
    #1;
    chk("sim_last_wb", {31'd0, stall}, 0);
    tick(); idle(); rs_used = 1;
    #1;
    chk("sim_cnt0", {31'd0, stall}, 0);
    chk("sim_no_unf", {31'd0, unf_err}, 0);
    idle();

    // cnt[r4]=2, wb+sq together clears it
    issue_en = 1; issue_addr = 4;
    tick(); tick(); idle();
    wb_en = 1; wb_addr = 4; wb_data = 32'h44; sq_en = 1; sq_addr = 4;
    tick(); idle();
    rs_addr = 4; rs_used = 1;
    #1;
    chk("wbsq_stall", {31'd0, stall}, 0);
    chk("wbsq_err", {30'd0, ovf_err, unf_err}, 0);
    chk("wbsq_data", rs_data, 32'h44);
    idle();

    // squash flush on r10
    issue_en = 1; issue_addr = 10;
    tick(); idle();
    wb_en = 1; wb_addr = 10; wb_data = 32'hA0;
    tick(); idle();
    issue_en = 1; issue_addr = 10;
    tick(); idle();
    rs_addr = 10; rs_used = 1;
    #1;
    chk("sq_pending", {31'd0, stall}, 1);
    sq_en = 1; sq_addr = 10;
    tick(); idle(); rs_used = 1;
    #1;
    chk("sq_stall", {31'd0, stall}, 0);
    chk("sq_data", rs_data, 32'hA0);
    chk("sq_no_unf", {31'd0, unf_err}, 0);
    idle();

    // saturation on r3
    issue_en = 1; issue_addr = 3;
    tick(); tick(); tick();
    #1;
    chk("sat_full", {31'd0, stall}, 1);
    chk("sat_no_ovf", {31'd0, ovf_err}, 0);
    tick(); idle();
    #1;
    chk("sat_ovf", {31'd0, ovf_err}, 1);
    wb_en = 1; wb_addr = 3; wb_data = 32'h31;
    tick(); tick(); idle();
    rs_addr = 3; rs_used = 1;
    #1;
    chk("sat_cnt1", {31'd0, stall}, 1);
    wb_en = 1; wb_addr = 3; wb_data = 32'h33;
    #1;
    chk("sat_last_wb", {31'd0, stall}, 0);
    tick(); idle(); rs_used = 1;
    #1;
    chk("sat_cnt0", {31'd0, stall}, 0);
    chk("sat_no_unf", {31'd0, unf_err}, 0);
    idle();
    wb_en = 1; wb_addr = 3; wb_data = 32'hCAFE;
    tick(); idle();
    #1;
    chk("sat_unf", {31'd0, unf_err}, 1);
    chk("sat_unf_data", rs_data, 32'hCAFE);

    // asynchronous reset mid-cycle with r8 pending
    issue_en = 1; issue_addr = 8;
    tick(); idle();
    rs_addr = 8; rs_used = 1;
    #1;
    chk("pre_rst_stall", {31'd0, stall}, 1);
    #1 reset = 0;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 0);
    chk("mid_rst_ovf", {31'd0, ovf_err}, 0);
    chk("mid_rst_unf", {31'd0, unf_err}, 0);
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a);
      #1;
      chk($sformatf("mid_rst_rs%0d", a), rs_data, 0);
      chk($sformatf("mid_rst_rt%0d", 31 - a), rt_data, 0);
    end
    reset = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
